// File: rtl/ysyx_23060111_mem_arbiter_if.sv
// Request/response bundle shared by the IFU, LSU and memory sides of the arbiter.
// The master issues requests and consumes responses; the slave does the opposite.
interface ysyx_23060111_mem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;

  modport master (
    output req_valid, addr, wen, wdata, wmask,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060111_mem_arbiter.sv
// Single-port memory arbiter between IFU and LSU: one latched transaction at a time,
// response routed to its owner, hung memory converted into an error response.
//
// state  | meaning
// IDLE   | no transaction; grant a requester and latch its fields
// REQ    | mem_req_valid held with latched fields until mem_req_ready
// WAIT   | waiting for mem_resp_valid, timeout counter running
// RESP   | one-cycle resp_valid pulse to the owner
module ysyx_23060111_mem_arbiter #(
  parameter int          LSU_PRIO = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_23060111_mem_arbiter_if.slave         ifu,
  ysyx_23060111_mem_arbiter_if.slave         lsu,
  ysyx_23060111_mem_arbiter_if.master        mem,
  output logic                               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               last_lsu_q, last_lsu_d;
  logic               owner_lsu_q, owner_lsu_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic               ifu_resp_valid_q, ifu_resp_valid_d;
  logic               lsu_resp_valid_q, lsu_resp_valid_d;
  logic               busy_q, busy_d;

  logic               is_idle;
  logic               grant_lsu;
  logic               grant_ifu;

  // Round-robin mode hands a tie to whichever master was not granted last.
  always_comb begin
    is_idle   = (state_q == S_IDLE);
    grant_lsu = lsu.req_valid &&
                (!ifu.req_valid || (LSU_PRIO != 0) || !last_lsu_q);
    grant_ifu = ifu.req_valid && !grant_lsu;
  end

  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    owner_lsu_d = owner_lsu_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          state_d     = S_REQ;
          owner_lsu_d = 1'b1;
          last_lsu_d  = 1'b1;
          addr_d      = lsu.addr;
          wen_d       = lsu.wen;
          wdata_d     = lsu.wdata;
          wmask_d     = lsu.wen ? lsu.wmask : 4'h0;
        end else if (grant_ifu) begin
          state_d     = S_REQ;
          owner_lsu_d = 1'b0;
          last_lsu_d  = 1'b0;
          addr_d      = ifu.addr;
          wen_d       = 1'b0;
          wdata_d     = 32'h0;
          wmask_d     = 4'h0;
        end
      end

      S_REQ: begin
        if (mem.req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the final counted cycle still wins over the timeout.
        if (mem.resp_valid) begin
          state_d = S_RESP;
          rdata_d = wen_q ? 32'h0 : mem.rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_req_valid_d  = (state_d == S_REQ);
    ifu_resp_valid_d = (state_d == S_RESP) && !owner_lsu_d;
    lsu_resp_valid_d = (state_d == S_RESP) &&  owner_lsu_d;
    busy_d           = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      last_lsu_q       <= 1'b0;
      owner_lsu_q      <= 1'b0;
      cnt_q            <= '0;
      addr_q           <= 32'h0;
      wen_q            <= 1'b0;
      wdata_q          <= 32'h0;
      wmask_q          <= 4'h0;
      rdata_q          <= 32'h0;
      err_q            <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_lsu_q       <= last_lsu_d;
      owner_lsu_q      <= owner_lsu_d;
      cnt_q            <= cnt_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      rdata_q          <= rdata_d;
      err_q            <= err_d;
      mem_req_valid_q  <= mem_req_valid_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      busy_q           <= busy_d;
    end
  end

  // Ready is the only combinational output: it must pulse in the granting cycle.
  assign ifu.req_ready  = is_idle && grant_ifu;
  assign lsu.req_ready  = is_idle && grant_lsu;

  assign ifu.resp_valid = ifu_resp_valid_q;
  assign ifu.rdata      = ifu_resp_valid_q ? rdata_q : 32'h0;
  assign ifu.resp_err   = ifu_resp_valid_q & err_q;

  assign lsu.resp_valid = lsu_resp_valid_q;
  assign lsu.rdata      = lsu_resp_valid_q ? rdata_q : 32'h0;
  assign lsu.resp_err   = lsu_resp_valid_q & err_q;

  assign mem.req_valid  = mem_req_valid_q;
  assign mem.addr       = addr_q;
  assign mem.wen        = wen_q;
  assign mem.wdata      = wdata_q;
  assign mem.wmask      = wmask_q;

  assign busy           = busy_q;

  // The fetch port never writes and the memory has no error line of its own.
  logic unused_inputs;
  assign unused_inputs = ^{ifu.wen, ifu.wdata, ifu.wmask, mem.resp_err};

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Directed bench for the memory arbiter: dut_a uses LSU priority, dut_b round-robin
// with a short timeout.
module tb_ysyx_23060111_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  int   errors = 0;
  int   checks = 0;
  bit   exp_ifu;

  always #5 clk = ~clk;

  ysyx_23060111_mem_arbiter_if ifu_a();
  ysyx_23060111_mem_arbiter_if lsu_a();
  ysyx_23060111_mem_arbiter_if mem_a();
  ysyx_23060111_mem_arbiter_if ifu_b();
  ysyx_23060111_mem_arbiter_if lsu_b();
  ysyx_23060111_mem_arbiter_if mem_b();

  ysyx_23060111_mem_arbiter #(.LSU_PRIO(1), .TIMEOUT(255), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .ifu(ifu_a), .lsu(lsu_a), .mem(mem_a), .busy(busy_a)
  );

  ysyx_23060111_mem_arbiter #(.LSU_PRIO(0), .TIMEOUT(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .ifu(ifu_b), .lsu(lsu_b), .mem(mem_b), .busy(busy_b)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ctl_a();
    return {19'd0, ifu_a.req_ready, ifu_a.resp_valid, ifu_a.resp_err,
            lsu_a.req_ready, lsu_a.resp_valid, lsu_a.resp_err,
            mem_a.req_valid, mem_a.wen, mem_a.wmask, busy_a};
  endfunction

  function automatic logic [31:0] ctl_b();
    return {19'd0, ifu_b.req_ready, ifu_b.resp_valid, ifu_b.resp_err,
            lsu_b.req_ready, lsu_b.resp_valid, lsu_b.resp_err,
            mem_b.req_valid, mem_b.wen, mem_b.wmask, busy_b};
  endfunction

  task automatic zero_inputs();
    ifu_a.req_valid = 1'b0; ifu_a.addr = 32'h0; ifu_a.wen = 1'b0; ifu_a.wdata = 32'h0; ifu_a.wmask = 4'h0;
    lsu_a.req_valid = 1'b0; lsu_a.addr = 32'h0; lsu_a.wen = 1'b0; lsu_a.wdata = 32'h0; lsu_a.wmask = 4'h0;
    ifu_b.req_valid = 1'b0; ifu_b.addr = 32'h0; ifu_b.wen = 1'b0; ifu_b.wdata = 32'h0; ifu_b.wmask = 4'h0;
    lsu_b.req_valid = 1'b0; lsu_b.addr = 32'h0; lsu_b.wen = 1'b0; lsu_b.wdata = 32'h0; lsu_b.wmask = 4'h0;
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0; mem_a.resp_err = 1'b0;
    mem_b.req_ready = 1'b0; mem_b.resp_valid = 1'b0; mem_b.rdata = 32'h0; mem_b.resp_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      smp();
      chk32("rst_ctl_a", ctl_a(), 32'h0);
      chk32("rst_dat_a", mem_a.addr | mem_a.wdata | ifu_a.rdata | lsu_a.rdata, 32'h0);
      chk32("rst_ctl_b", ctl_b(), 32'h0);
      chk32("rst_dat_b", mem_b.addr | mem_b.wdata | ifu_b.rdata | lsu_b.rdata, 32'h0);
      tick();
    end

    // single fetch, zero-wait memory
    ifu_a.req_valid = 1'b1; ifu_a.addr = 32'h8000_0000;
    smp();
    chk1("f_ifu_rdy", ifu_a.req_ready, 1'b1);
    chk1("f_lsu_rdy", lsu_a.req_ready, 1'b0);
    chk1("f_memv0", mem_a.req_valid, 1'b0);
    tick();
    ifu_a.req_valid = 1'b0; ifu_a.addr = 32'h0; mem_a.req_ready = 1'b1;
    smp();
    chk1("f_memv", mem_a.req_valid, 1'b1);
    chk32("f_addr", mem_a.addr, 32'h8000_0000);
    chk1("f_wen", mem_a.wen, 1'b0);
    chk1("f_busy1", busy_a, 1'b1);
    chk1("f_ifu_rdy1", ifu_a.req_ready, 1'b0);
    tick();
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b1; mem_a.rdata = 32'h0010_0093;
    smp();
    chk1("f_memv2", mem_a.req_valid, 1'b0);
    chk1("f_rv_early", ifu_a.resp_valid, 1'b0);
    tick();
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0;
    smp();
    chk1("f_rv", ifu_a.resp_valid, 1'b1);
    chk32("f_rdata", ifu_a.rdata, 32'h0010_0093);
    chk1("f_err", ifu_a.resp_err, 1'b0);
    chk1("f_lsu_rv", lsu_a.resp_valid, 1'b0);
    tick();
    smp();
    chk1("f_rv_pulse", ifu_a.resp_valid, 1'b0);
    chk1("f_busy_end", busy_a, 1'b0);
    tick();

    // simultaneous requests, LSU priority
    ifu_a.req_valid = 1'b1; ifu_a.addr = 32'h8000_0004;
    lsu_a.req_valid = 1'b1; lsu_a.wen = 1'b1; lsu_a.addr = 32'h8000_1000;
    lsu_a.wdata = 32'hDEAD_BEEF; lsu_a.wmask = 4'hF;
    smp();
    chk1("s_lsu_rdy", lsu_a.req_ready, 1'b1);
    chk1("s_ifu_rdy", ifu_a.req_ready, 1'b0);
    tick();
    lsu_a.req_valid = 1'b0; lsu_a.wen = 1'b0; lsu_a.addr = 32'h0;
    lsu_a.wdata = 32'h0; lsu_a.wmask = 4'h0; mem_a.req_ready = 1'b1;
    smp();
    chk32("s_addr", mem_a.addr, 32'h8000_1000);
    chk1("s_wen", mem_a.wen, 1'b1);
    chk32("s_wdata", mem_a.wdata, 32'hDEAD_BEEF);
    chk32("s_wmask", {28'd0, mem_a.wmask}, 32'hF);
    chk1("s_ifu_rdy1", ifu_a.req_ready, 1'b0);
    tick();
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b1; mem_a.rdata = 32'h1234_5678;
    smp();
    chk1("s_ifu_rdy2", ifu_a.req_ready, 1'b0);
    tick();
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0;
    smp();
    chk1("s_lsu_rv", lsu_a.resp_valid, 1'b1);
    chk32("s_lsu_rdata", lsu_a.rdata, 32'h0);
    chk1("s_ifu_rv", ifu_a.resp_valid, 1'b0);
    chk1("s_ifu_rdy3", ifu_a.req_ready, 1'b0);
    tick();
    smp();
    chk1("s_ifu_rdy4", ifu_a.req_ready, 1'b1);
    chk1("s_lsu_rv_pulse", lsu_a.resp_valid, 1'b0);
    tick();
    ifu_a.req_valid = 1'b0; mem_a.req_ready = 1'b1;
    smp();
    chk32("s_f_addr", mem_a.addr, 32'h8000_0004);
    chk1("s_f_wen", mem_a.wen, 1'b0);
    chk32("s_f_wdata", mem_a.wdata, 32'h0);
    chk32("s_f_wmask", {28'd0, mem_a.wmask}, 32'h0);
    tick();
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b1; mem_a.rdata = 32'hAABB_CCDD;
    tick();
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0;
    smp();
    chk1("s_f_rv", ifu_a.resp_valid, 1'b1);
    chk32("s_f_rdata", ifu_a.rdata, 32'hAABB_CCDD);
    chk1("s_f_lsu_rv", lsu_a.resp_valid, 1'b0);
    tick();

    // memory stall: LSU load, ready late, response 20 cycles into WAIT
    lsu_a.req_valid = 1'b1; lsu_a.wen = 1'b0; lsu_a.addr = 32'h8000_2000;
    lsu_a.wmask = 4'hF; lsu_a.wdata = 32'h1111_1111;
    smp();
    chk1("st_rdy", lsu_a.req_ready, 1'b1);
    tick();
    lsu_a.req_valid = 1'b0; lsu_a.wmask = 4'h0; lsu_a.addr = 32'h0; lsu_a.wdata = 32'h0;
    ifu_a.req_valid = 1'b1; ifu_a.addr = 32'h8000_0008;
    for (int i = 0; i < 5; i++) begin
      mem_a.resp_valid = (i == 2);
      mem_a.rdata      = (i == 2) ? 32'hBAD0_BAD0 : 32'h0;
      smp();
      chk1("st_req_v", mem_a.req_valid, 1'b1);
      chk32("st_addr", mem_a.addr, 32'h8000_2000);
      chk32("st_wmask", {28'd0, mem_a.wmask}, 32'h0);
      chk1("st_wen", mem_a.wen, 1'b0);
      chk1("st_ifu_rdy", ifu_a.req_ready, 1'b0);
      chk1("st_lsu_rv", lsu_a.resp_valid, 1'b0);
      tick();
    end
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0; mem_a.req_ready = 1'b1;
    smp();
    chk1("st_req_v5", mem_a.req_valid, 1'b1);
    chk32("st_addr5", mem_a.addr, 32'h8000_2000);
    tick();
    for (int i = 0; i < 20; i++) begin
      smp();
      chk1("st_wait_rv", lsu_a.resp_valid, 1'b0);
      chk1("st_wait_memv", mem_a.req_valid, 1'b0);
      chk1("st_wait_busy", busy_a, 1'b1);
      chk1("st_wait_ifu_rdy", ifu_a.req_ready, 1'b0);
      tick();
    end
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b1; mem_a.rdata = 32'hCAFE_F00D;
    smp();
    chk1("st_rv_early", lsu_a.resp_valid, 1'b0);
    tick();
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0;
    smp();
    chk1("st_rv", lsu_a.resp_valid, 1'b1);
    chk32("st_rdata", lsu_a.rdata, 32'hCAFE_F00D);
    chk1("st_err", lsu_a.resp_err, 1'b0);
    chk1("st_ifu_rv", ifu_a.resp_valid, 1'b0);
    chk1("st_ifu_rdy_resp", ifu_a.req_ready, 1'b0);
    tick();
    smp();
    chk1("st_rv_pulse", lsu_a.resp_valid, 1'b0);
    chk1("st_ifu_rdy_idle", ifu_a.req_ready, 1'b1);
    tick();
    ifu_a.req_valid = 1'b0; mem_a.req_ready = 1'b1;
    smp();
    chk32("st_f_addr", mem_a.addr, 32'h8000_0008);
    tick();
    mem_a.req_ready = 1'b0; mem_a.resp_valid = 1'b1; mem_a.rdata = 32'h0000_0013;
    tick();
    mem_a.resp_valid = 1'b0; mem_a.rdata = 32'h0;
    smp();
    chk1("st_f_rv", ifu_a.resp_valid, 1'b1);
    chk32("st_f_rdata", ifu_a.rdata, 32'h0000_0013);
    tick();

    // timeout on dut_b (TIMEOUT=8)
    lsu_b.req_valid = 1'b1; lsu_b.addr = 32'h8000_3000;
    smp();
    chk1("to_rdy", lsu_b.req_ready, 1'b1);
    tick();
    lsu_b.req_valid = 1'b0; mem_b.req_ready = 1'b1;
    smp();
    chk1("to_memv", mem_b.req_valid, 1'b1);
    tick();
    mem_b.req_ready = 1'b0; mem_b.rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk1("to_wait_rv", lsu_b.resp_valid, 1'b0);
      chk1("to_busy", busy_b, 1'b1);
      tick();
    end
    smp();
    chk1("to_rv", lsu_b.resp_valid, 1'b1);
    chk1("to_err", lsu_b.resp_err, 1'b1);
    chk32("to_rdata", lsu_b.rdata, 32'h0);
    chk1("to_ifu_rv", ifu_b.resp_valid, 1'b0);
    tick();
    mem_b.rdata = 32'h0;
    smp();
    chk1("to_pulse", lsu_b.resp_valid, 1'b0);
    chk1("to_busy_end", busy_b, 1'b0);
    tick();

    // response on the 8th WAIT cycle beats the timeout
    lsu_b.req_valid = 1'b1; lsu_b.addr = 32'h8000_3004;
    smp();
    chk1("tr_rdy", lsu_b.req_ready, 1'b1);
    tick();
    lsu_b.req_valid = 1'b0; mem_b.req_ready = 1'b1;
    tick();
    mem_b.req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      smp();
      chk1("tr_wait_rv", lsu_b.resp_valid, 1'b0);
      tick();
    end
    mem_b.resp_valid = 1'b1; mem_b.rdata = 32'h5A5A_5A5A;
    smp();
    chk1("tr_wait8_rv", lsu_b.resp_valid, 1'b0);
    tick();
    mem_b.resp_valid = 1'b0; mem_b.rdata = 32'h0;
    smp();
    chk1("tr_rv", lsu_b.resp_valid, 1'b1);
    chk1("tr_err", lsu_b.resp_err, 1'b0);
    chk32("tr_rdata", lsu_b.rdata, 32'h5A5A_5A5A);
    tick();

    // round-robin with both continuously valid; LSU was granted last
    ifu_b.req_valid = 1'b1; ifu_b.addr = 32'h8000_0010;
    lsu_b.req_valid = 1'b1; lsu_b.addr = 32'h8000_4000; lsu_b.wen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_ifu = (k != 1);
      smp();
      chk1("rr_ifu_rdy", ifu_b.req_ready, exp_ifu);
      chk1("rr_lsu_rdy", lsu_b.req_ready, !exp_ifu);
      tick();
      mem_b.req_ready = 1'b1;
      smp();
      chk32("rr_addr", mem_b.addr, exp_ifu ? 32'h8000_0010 : 32'h8000_4000);
      tick();
      mem_b.req_ready = 1'b0; mem_b.resp_valid = 1'b1; mem_b.rdata = 32'h100 + 32'(k);
      tick();
      mem_b.resp_valid = 1'b0; mem_b.rdata = 32'h0;
      smp();
      chk1("rr_ifu_rv", ifu_b.resp_valid, exp_ifu);
      chk1("rr_lsu_rv", lsu_b.resp_valid, !exp_ifu);
      tick();
    end
    ifu_b.req_valid = 1'b0; lsu_b.req_valid = 1'b0;
    tick();

    // reset during WAIT of a load
    lsu_b.req_valid = 1'b1; lsu_b.addr = 32'h8000_5000;
    smp();
    chk1("rw_rdy", lsu_b.req_ready, 1'b1);
    tick();
    lsu_b.req_valid = 1'b0; mem_b.req_ready = 1'b1;
    tick();
    mem_b.req_ready = 1'b0;
    tick();
    rst = 1'b1;
    smp();
    chk1("rw_busy_pre", busy_b, 1'b1);
    tick();
    rst = 1'b0;
    ifu_b.req_valid = 1'b1; ifu_b.addr = 32'h8000_0020;
    smp();
    chk1("rw_busy", busy_b, 1'b0);
    chk1("rw_lsu_rv", lsu_b.resp_valid, 1'b0);
    chk32("rw_addr_clr", mem_b.addr, 32'h0);
    chk1("rw_ifu_rdy", ifu_b.req_ready, 1'b1);
    tick();
    ifu_b.req_valid = 1'b0; mem_b.req_ready = 1'b1;
    smp();
    chk32("rw_f_addr", mem_b.addr, 32'h8000_0020);
    chk1("rw_lsu_rv1", lsu_b.resp_valid, 1'b0);
    tick();
    mem_b.req_ready = 1'b0; mem_b.resp_valid = 1'b1; mem_b.rdata = 32'h0000_0297;
    smp();
    chk1("rw_lsu_rv2", lsu_b.resp_valid, 1'b0);
    tick();
    mem_b.resp_valid = 1'b0; mem_b.rdata = 32'h0;
    smp();
    chk1("rw_f_rv", ifu_b.resp_valid, 1'b1);
    chk32("rw_f_rdata", ifu_b.rdata, 32'h0000_0297);
    chk1("rw_lsu_rv3", lsu_b.resp_valid, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
